instr_mem_loader: RTL and testbench

Byte-stream boot loader that writes a program image into instruction memory while the core is held off. It accepts bytes over a valid/ready handshake: a 4-byte little-endian length header, then payload, then a checksum byte. It packs payload bytes little-endian into 32-bit words with byte enables, so byte `n` of the image lands at byte address `BASE_ADR + n`. It asserts a core hold for the whole load.

---
 rtl/instr_mem_loader.sv | 165 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes
// it into instruction memory as byte-enabled 32-bit words while holding the core.
module instr_mem_loader #(
   parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
   parameter logic [31:0] MAX_BYTES = 32'h0010_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic        o_byte_ready,
   output logic        o_we,
   output logic [31:0] o_adr,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_be,
   output logic        o_cpu_hold,
   output logic        o_done,
   output logic        o_err,
   output logic [1:0]  o_err_code
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   state_t      state_r;
   logic [31:0] cnt_r;
   logic [31:0] len_r;
   logic [7:0]  csum_r;
   logic [31:0] buf_r;
   logic [3:0]  be_r;

   logic        accept_s;
   logic [1:0]  lane_s;
   logic        last_s;
   logic [31:0] full_len_s;
   logic [7:0]  csum_next_s;
   logic [31:0] buf_s;
   logic [3:0]  be_s;

   assign accept_s    = i_byte_valid & o_byte_ready;
   assign lane_s      = cnt_r[1:0];
   assign last_s      = (cnt_r == (len_r - 32'd1));
   // Header arrives LSB first, so shifting in from the top leaves byte 0 at [7:0].
   assign full_len_s  = {i_byte, len_r[31:8]};
   assign csum_next_s = csum_r + i_byte;
   assign be_s        = be_r | (4'b0001 << lane_s);

   // Word buffer with the incoming byte merged into its lane.
   always_comb begin
      buf_s = buf_r;
      case (lane_s)
         2'd0:    buf_s[7:0]   = i_byte;
         2'd1:    buf_s[15:8]  = i_byte;
         2'd2:    buf_s[23:16] = i_byte;
         2'd3:    buf_s[31:24] = i_byte;
         default: buf_s        = buf_r;
      endcase
   end

   // Load sequencer with all outputs registered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= 32'd0;
         len_r        <= 32'd0;
         csum_r       <= 8'd0;
         buf_r        <= 32'd0;
         be_r         <= 4'd0;
         o_byte_ready <= 1'b0;
         o_we         <= 1'b0;
         o_adr        <= 32'd0;
         o_wdata      <= 32'd0;
         o_be         <= 4'd0;
         o_cpu_hold   <= 1'b0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_err_code   <= 2'd0;
      end else begin
         o_we <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (i_start) begin
                  state_r      <= ST_LEN;
                  cnt_r        <= 32'd0;
                  len_r        <= 32'd0;
                  csum_r       <= 8'd0;
                  buf_r        <= 32'd0;
                  be_r         <= 4'd0;
                  o_byte_ready <= 1'b1;
                  o_cpu_hold   <= 1'b1;
                  o_done       <= 1'b0;
                  o_err        <= 1'b0;
                  o_err_code   <= 2'd0;
               end
            end
            ST_LEN: begin
               if (accept_s) begin
                  len_r <= full_len_s;
                  if (cnt_r[1:0] == 2'd3) begin
                     cnt_r <= 32'd0;
                     if (full_len_s == 32'd0) begin
                        state_r <= ST_CSUM;
                     end else if (full_len_s > MAX_BYTES) begin
                        state_r      <= ST_ERR;
                        o_byte_ready <= 1'b0;
                        o_err        <= 1'b1;
                        o_err_code   <= 2'd1;
                     end else begin
                        state_r <= ST_DATA;
                     end
                  end else begin
                     cnt_r <= cnt_r + 32'd1;
                  end
               end
            end
            ST_DATA: begin
               if (accept_s) begin
                  csum_r <= csum_next_s;
                  cnt_r  <= cnt_r + 32'd1;
                  if ((lane_s == 2'd3) || last_s) begin
                     o_we    <= 1'b1;
                     o_adr   <= BASE_ADR + {cnt_r[31:2], 2'b00};
                     o_wdata <= buf_s;
                     o_be    <= be_s;
                     buf_r   <= 32'd0;
                     be_r    <= 4'd0;
                  end else begin
                     buf_r <= buf_s;
                     be_r  <= be_s;
                  end
                  if (last_s) begin
                     state_r <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (accept_s) begin
                  o_byte_ready <= 1'b0;
                  if (csum_next_s == 8'd0) begin
                     state_r    <= ST_DONE;
                     o_done     <= 1'b1;
                     o_cpu_hold <= 1'b0;
                  end else begin
                     state_r    <= ST_ERR;
                     o_err      <= 1'b1;
                     o_err_code <= 2'd2;
                  end
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               o_byte_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: directed and random loads checked against an
// image-level model of expected words, flags and error codes.
module tb_instr_mem_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam logic [31:0] MAXB = 32'h0010_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        bv;
   logic [7:0]  bt;
   logic        o_byte_ready;
   logic        o_we;
   logic [31:0] o_adr;
   logic [31:0] o_wdata;
   logic [3:0]  o_be;
   logic        o_cpu_hold;
   logic        o_done;
   logic        o_err;
   logic [1:0]  o_err_code;

   int n_chk  = 0;
   int n_fail = 0;
   int hold_viol = 0;
   logic [67:0] wq[$];

   always #5 clk = ~clk;

   instr_mem_loader #(.BASE_ADR(BASE), .MAX_BYTES(MAXB)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .i_byte_valid(bv), .i_byte(bt), .o_byte_ready(o_byte_ready),
      .o_we(o_we), .o_adr(o_adr), .o_wdata(o_wdata), .o_be(o_be),
      .o_cpu_hold(o_cpu_hold), .o_done(o_done), .o_err(o_err),
      .o_err_code(o_err_code)
   );

   // Write monitor: captures every memory write seen mid-cycle.
   always @(negedge clk) begin
      if (o_we) begin
         wq.push_back({o_adr, o_wdata, o_be});
         if (!o_cpu_hold) hold_viol++;
      end
   end

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered and left on a negedge; presents one byte until the loader takes it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int tmo;
      repeat (gap) @(negedge clk);
      bv  = 1'b1;
      bt  = b;
      tmo = 0;
      while (!o_byte_ready && tmo < 100) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 100) chk("ready_timeout", {95'd0, o_byte_ready}, 96'd1);
      else @(negedge clk);
      bv = 1'b0;
   endtask

   task automatic run_load(input logic [31:0] len_f, input logic [7:0] pl[$],
                           input logic [7:0] cs, input int gap, input string tag);
      logic [7:0]  sum;
      logic        ok;
      logic [31:0] d;
      logic [3:0]  e;
      logic [67:0] exp_q[$];
      wq.delete();
      hold_viol = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start"}, {90'd0, o_byte_ready, o_cpu_hold, o_done, o_err, o_err_code},
          {90'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0});
      for (int i = 0; i < 4; i++) send_byte(len_f[8*i +: 8], gap);
      if (len_f > MAXB) begin
         chk({tag, "_oversize"}, {91'd0, o_byte_ready, o_err, o_err_code, o_cpu_hold},
             {91'd0, 1'b0, 1'b1, 2'd1, 1'b1});
         repeat (3) @(negedge clk);
         chk({tag, "_oversize_nwr"}, 96'(wq.size()), 96'd0);
         return;
      end
      foreach (pl[i]) send_byte(pl[i], gap);
      send_byte(cs, gap);

      sum = cs;
      foreach (pl[i]) sum = sum + pl[i];
      ok = (sum == 8'd0);
      for (int w = 0; w * 4 < pl.size(); w++) begin
         d = 32'd0;
         e = 4'd0;
         for (int k = 0; k < 4; k++) begin
            if (w * 4 + k < pl.size()) begin
               d[8*k +: 8] = pl[w*4+k];
               e[k] = 1'b1;
            end
         end
         exp_q.push_back({BASE + 32'(w * 4), d, e});
      end

      chk({tag, "_flags"}, {90'd0, o_byte_ready, o_done, o_err, o_err_code, o_cpu_hold},
          {90'd0, 1'b0, ok, !ok, (ok ? 2'd0 : 2'd2), !ok});
      chk({tag, "_nwr"}, 96'(wq.size()), 96'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
         chk({tag, "_wr"}, {28'd0, wq[i]}, {28'd0, exp_q[i]});
      chk({tag, "_hold_wr"}, 96'(hold_viol), 96'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  q[$];
      logic [7:0]  s;
      logic [31:0] len;
      rst = 1'b1; start = 1'b0; bv = 1'b0; bt = 8'd0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {21'd0, o_byte_ready, o_we, o_adr, o_wdata, o_be, o_cpu_hold, o_done, o_err, o_err_code}, 96'd0);
      rst = 1'b0;
      @(negedge clk);

      q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      run_load(32'd8, q, 8'h7E, 0, "two_word");
      run_load(32'd8, q, 8'h7F, 0, "bad_csum");
      q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      run_load(32'd5, q, 8'h01, 0, "tail");
      q.delete();
      run_load(32'h0010_0001, q, 8'h00, 0, "oversize");

      // Reset lands on the edge that would have completed the first word.
      wq.delete();
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd8 : 8'd0, 0);
      for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i), 0);
      bv = 1'b1; bt = 8'hA3; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; bv = 1'b0;
      chk("rst_mid_outs", {21'd0, o_byte_ready, o_we, o_adr, o_wdata, o_be, o_cpu_hold, o_done, o_err, o_err_code}, 96'd0);
      repeat (3) @(negedge clk);
      chk("rst_mid_nwr", 96'(wq.size()), 96'd0);
      q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      run_load(32'd8, q, 8'h7E, 0, "after_rst");

      q.delete();
      run_load(32'd0, q, 8'h00, 1, "zero_len");

      for (int t = 0; t < 30; t++) begin
         q.delete();
         if ($urandom_range(0, 7) == 0) begin
            len = (t % 2 == 0) ? 32'hFFFF_FFFF : MAXB + 32'd1 + 32'($urandom_range(0, 1000));
            run_load(len, q, 8'h00, $urandom_range(0, 2), "rnd_over");
         end else begin
            len = 32'($urandom_range(0, 40));
            s = 8'd0;
            for (int i = 0; i < int'(len); i++) begin
               q.push_back(8'($urandom_range(0, 255)));
               s = s + q[i];
            end
            s = 8'd0 - s;
            if ($urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
            run_load(len, q, s, $urandom_range(0, 2), "rnd");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
